// File: rtl/regfile_pkg.sv
// Shared widths, opcode and FSM state encodings for the register-file command controller.
package regfile_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [2:0] {
        OpNop  = 3'd0,
        OpLdi  = 3'd1,
        OpMov  = 3'd2,
        OpAdd  = 3'd3,
        OpSub  = 3'd4,
        OpSwap = 3'd5
    } rf_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StLat,
        StWr,
        StWr2,
        StDone
    } rf_ctrl_state_e;

    // Opcodes 6 and 7 have no operation behind them.
    function automatic logic op_is_illegal(logic [2:0] op);
        return op > 3'd5;
    endfunction

    function automatic logic op_reads_rf(logic [2:0] op);
        return (op == OpMov) || (op == OpAdd) || (op == OpSub) || (op == OpSwap);
    endfunction

endpackage

// File: rtl/rf_alu.sv
// Combinational result/carry generation for the write phase of each command.
module rf_alu #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] op0_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);
    import regfile_pkg::*;

    logic [DATA_W:0] sum;

    assign sum = {1'b0, op0_i} + {1'b0, op1_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OpLdi: result_o = imm_i;
            OpMov: result_o = op0_i;
            OpAdd: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OpSub: begin
                result_o = op0_i - op1_i;
                carry_o  = op0_i < op1_i;
            end
            // The first SWAP write stores src1's value into src0.
            OpSwap: result_o = op1_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Single-command initiator for the 8x16 register file: sequences read, capture and write
// phases around the file's one-cycle registered read, then pulses a completion response.
module regfile_ctrl #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_rd0_addr,
    output logic [ADDR_W-1:0] rf_rd1_addr,
    input  logic [DATA_W-1:0] rf_rd0_data,
    input  logic [DATA_W-1:0] rf_rd1_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_carry,
    output logic              resp_zero,
    output logic              resp_err
);
    import regfile_pkg::*;

    rf_ctrl_state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dst_q, src0_q, src1_q;
    logic [DATA_W-1:0] imm_q, op0_q, op1_q;

    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_carry_q, resp_carry_d;
    logic              resp_zero_q, resp_zero_d;
    logic              resp_err_q, resp_err_d;

    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    rf_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op_i    (op_q),
        .op0_i   (op0_q),
        .op1_i   (op1_q),
        .imm_i   (imm_q),
        .result_o(alu_result),
        .carry_o (alu_carry)
    );

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready && !rst;

    always_comb begin
        state_d      = state_q;
        resp_data_d  = resp_data_q;
        resp_carry_d = resp_carry_q;
        resp_zero_d  = resp_zero_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd_op == OpLdi) begin
                        state_d = StWr;
                    end else if (op_reads_rf(cmd_op)) begin
                        state_d = StRd;
                    end else begin
                        state_d      = StDone;
                        resp_data_d  = '0;
                        resp_carry_d = 1'b0;
                        resp_zero_d  = 1'b1;
                        resp_err_d   = op_is_illegal(cmd_op);
                    end
                end
            end
            StRd:  state_d = StLat;
            StLat: state_d = StWr;
            StWr: begin
                if (op_q == OpSwap) begin
                    state_d = StWr2;
                end else begin
                    state_d      = StDone;
                    resp_data_d  = alu_result;
                    resp_carry_d = alu_carry;
                    resp_zero_d  = (alu_result == '0);
                    resp_err_d   = 1'b0;
                end
            end
            StWr2: begin
                state_d      = StDone;
                resp_data_d  = op0_q;
                resp_carry_d = 1'b0;
                resp_zero_d  = (op0_q == '0);
                resp_err_d   = 1'b0;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rf_rd0_addr = src0_q;
        rf_rd1_addr = src1_q;
        // Gated with rst so an aborted command can never land a write.
        rf_wr_en    = ((state_q == StWr) || (state_q == StWr2)) && !rst;
        if (state_q == StWr2) begin
            rf_wr_addr = src1_q;
            rf_wr_data = op0_q;
        end else begin
            rf_wr_addr = (op_q == OpSwap) ? src0_q : dst_q;
            rf_wr_data = alu_result;
        end
        resp_valid = (state_q == StDone);
        resp_data  = resp_data_q;
        resp_carry = resp_carry_q;
        resp_zero  = resp_zero_q;
        resp_err   = resp_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            dst_q        <= '0;
            src0_q       <= '0;
            src1_q       <= '0;
            imm_q        <= '0;
            op0_q        <= '0;
            op1_q        <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            resp_zero_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            resp_carry_q <= resp_carry_d;
            resp_zero_q  <= resp_zero_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                op_q   <= cmd_op;
                dst_q  <= cmd_dst;
                src0_q <= cmd_src0;
                src1_q <= cmd_src1;
                imm_q  <= cmd_imm;
            end
            // Read data registered at the end of RD is valid throughout LAT.
            if (state_q == StLat) begin
                op0_q <= rf_rd0_data;
                op1_q <= rf_rd1_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl driving a behavioural 8x16 register file with registered reads.
module tb_regfile_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src0;
    logic [2:0]  cmd_src1;
    logic [15:0] cmd_imm;
    logic [2:0]  rf_rd0_addr;
    logic [2:0]  rf_rd1_addr;
    logic [15:0] rf_rd0_data;
    logic [15:0] rf_rd1_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_carry;
    logic        resp_zero;
    logic        resp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_ctrl #(
        .DATA_W(16),
        .ADDR_W(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dst    (cmd_dst),
        .cmd_src0   (cmd_src0),
        .cmd_src1   (cmd_src1),
        .cmd_imm    (cmd_imm),
        .rf_rd0_addr(rf_rd0_addr),
        .rf_rd1_addr(rf_rd1_addr),
        .rf_rd0_data(rf_rd0_data),
        .rf_rd1_data(rf_rd1_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err)
    );

    // Register file: synchronous write, registered read.
    logic [15:0] regs [8];
    always_ff @(posedge clk) begin
        if (rf_wr_en) regs[rf_wr_addr] <= rf_wr_data;
        rf_rd0_data <= regs[rf_rd0_addr];
        rf_rd1_data <= regs[rf_rd1_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  dst;
        logic [2:0]  s0;
        logic [2:0]  s1;
        logic [15:0] imm;
        int          nwr;
        int          wk;
        int          lat;
        logic [2:0]  wa0;
        logic [15:0] wd0;
        logic [2:0]  wa1;
        logic [15:0] wd1;
        logic [15:0] data;
        logic        carry;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [2:0] op, dst, s0, s1, input logic [15:0] imm,
                               input int nwr, wk, lat, input logic [2:0] wa0,
                               input logic [15:0] wd0, input logic [2:0] wa1,
                               input logic [15:0] wd1, input logic [15:0] data,
                               input logic c, z, e);
        vec_t r;
        r.op = op; r.dst = dst; r.s0 = s0; r.s1 = s1; r.imm = imm;
        r.nwr = nwr; r.wk = wk; r.lat = lat;
        r.wa0 = wa0; r.wd0 = wd0; r.wa1 = wa1; r.wd1 = wd1;
        r.data = data; r.carry = c; r.zero = z; r.err = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [2:0] op, dst, s0, s1, input logic [15:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src0  = s0;
        cmd_src1  = s1;
        cmd_imm   = imm;
    endtask

    // Entered just after a falling edge; returns just after a falling edge.
    task automatic run_vec(input int id, input vec_t t);
        int          nwr = 0;
        int          wk  = 0;
        int          lat = 0;
        logic [2:0]  wa [2] = '{3'd0, 3'd0};
        logic [15:0] wd [2] = '{16'd0, 16'd0};
        logic [15:0] rd = '0;
        logic        rc = 1'b0, rz = 1'b0, re = 1'b0, rdy = 1'b1;
        string       p = $sformatf("v%0d", id);
        drive_cmd(t.op, t.dst, t.s0, t.s1, t.imm);
        #1 check({p, " ready_idle"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (rf_wr_en) begin
                if (nwr < 2) begin
                    wa[nwr] = rf_wr_addr;
                    wd[nwr] = rf_wr_data;
                end
                if (nwr == 0) wk = k;
                nwr++;
            end
            if (resp_valid) begin
                lat = k;
                rd  = resp_data;
                rc  = resp_carry;
                rz  = resp_zero;
                re  = resp_err;
                rdy = cmd_ready;
            end
        end
        check({p, " resp_latency"}, 32'(lat), 32'(t.lat));
        check({p, " write_count"}, 32'(nwr), 32'(t.nwr));
        if (t.nwr >= 1) begin
            check({p, " first_write_cycle"}, 32'(wk), 32'(t.wk));
            check({p, " wr0_addr"}, 32'(wa[0]), 32'(t.wa0));
            check({p, " wr0_data"}, 32'(wd[0]), 32'(t.wd0));
        end
        if (t.nwr >= 2) begin
            check({p, " wr1_addr"}, 32'(wa[1]), 32'(t.wa1));
            check({p, " wr1_data"}, 32'(wd[1]), 32'(t.wd1));
        end
        check({p, " resp_data"}, 32'(rd), 32'(t.data));
        check({p, " resp_carry"}, 32'(rc), 32'(t.carry));
        check({p, " resp_zero"}, 32'(rz), 32'(t.zero));
        check({p, " resp_err"}, 32'(re), 32'(t.err));
        check({p, " ready_busy"}, 32'(rdy), 32'd0);
        @(negedge clk);
        check({p, " resp_pulse"}, 32'(resp_valid), 32'd0);
        check({p, " ready_next"}, 32'(cmd_ready), 32'd1);
    endtask

    // Raise rst at the rst_k-th falling edge after accept; nothing may be written or reported.
    task automatic abort_case(input string name, input logic [2:0] op, dst, s0, s1,
                              input logic [15:0] imm, input int rst_k);
        int seen_wr   = 0;
        int seen_resp = 0;
        drive_cmd(op, dst, s0, s1, imm);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (rst_k) @(negedge clk);
        rst = 1'b1;
        #1;
        if (rf_wr_en) seen_wr++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rf_wr_en) seen_wr++;
            if (resp_valid) seen_resp++;
            @(negedge clk);
        end
        check({name, " no_write"}, 32'(seen_wr), 32'd0);
        check({name, " no_resp"}, 32'(seen_resp), 32'd0);
        check({name, " idle_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_dst   = '0;
        cmd_src0  = '0;
        cmd_src1  = '0;
        cmd_imm   = '0;

        //       op dst s0 s1 imm       nwr wk lat wa0 wd0       wa1 wd1       data      c  z  e
        vecs.push_back(v(1, 3, 0, 0, 16'h1234, 1, 1, 2, 3, 16'h1234, 0, 16'h0000, 16'h1234, 0, 0, 0));
        vecs.push_back(v(1, 3, 0, 0, 16'hFFFF, 1, 1, 2, 3, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 0, 0, 0));
        vecs.push_back(v(1, 4, 0, 0, 16'h0002, 1, 1, 2, 4, 16'h0002, 0, 16'h0000, 16'h0002, 0, 0, 0));
        vecs.push_back(v(3, 5, 3, 4, 16'h0000, 1, 3, 4, 5, 16'h0001, 0, 16'h0000, 16'h0001, 1, 0, 0));
        vecs.push_back(v(3, 6, 3, 3, 16'h0000, 1, 3, 4, 6, 16'hFFFE, 0, 16'h0000, 16'hFFFE, 1, 0, 0));
        vecs.push_back(v(1, 2, 0, 0, 16'h00AA, 1, 1, 2, 2, 16'h00AA, 0, 16'h0000, 16'h00AA, 0, 0, 0));
        vecs.push_back(v(4, 1, 2, 2, 16'h0000, 1, 3, 4, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 16'h0000, 1, 1, 2, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0));
        vecs.push_back(v(1, 7, 0, 0, 16'h0001, 1, 1, 2, 7, 16'h0001, 0, 16'h0000, 16'h0001, 0, 0, 0));
        vecs.push_back(v(4, 1, 0, 7, 16'h0000, 1, 3, 4, 1, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 1, 0, 0));
        vecs.push_back(v(2, 2, 1, 5, 16'h0000, 1, 3, 4, 2, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 16'hAAAA, 1, 1, 2, 0, 16'hAAAA, 0, 16'h0000, 16'hAAAA, 0, 0, 0));
        vecs.push_back(v(1, 7, 0, 0, 16'h5555, 1, 1, 2, 7, 16'h5555, 0, 16'h0000, 16'h5555, 0, 0, 0));
        vecs.push_back(v(5, 3, 0, 7, 16'h0000, 2, 3, 5, 0, 16'h5555, 7, 16'hAAAA, 16'hAAAA, 0, 0, 0));
        vecs.push_back(v(2, 4, 0, 6, 16'h0000, 1, 3, 4, 4, 16'h5555, 0, 16'h0000, 16'h5555, 0, 0, 0));
        vecs.push_back(v(2, 5, 7, 6, 16'h0000, 1, 3, 4, 5, 16'hAAAA, 0, 16'h0000, 16'hAAAA, 0, 0, 0));
        vecs.push_back(v(7, 3, 0, 7, 16'h1111, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1));
        vecs.push_back(v(0, 3, 0, 7, 16'h2222, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0));
        vecs.push_back(v(6, 1, 2, 3, 16'h3333, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1));
        vecs.push_back(v(5, 0, 2, 2, 16'h0000, 2, 3, 5, 2, 16'hFFFF, 2, 16'hFFFF, 16'hFFFF, 0, 0, 0));
        vecs.push_back(v(3, 6, 4, 5, 16'h0000, 1, 3, 4, 6, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 0, 0, 0));

        // Reset held with a live LDI on the command bus: nothing may happen.
        drive_cmd(3'd1, 3'd3, 3'd0, 3'd0, 16'hDEAD);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("reset wr_en", 32'(rf_wr_en), 32'd0);
            check("reset resp_valid", 32'(resp_valid), 32'd0);
            check("reset resp_data", 32'(resp_data), 32'd0);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1 check("ready after reset", 32'(cmd_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("post-reset wr_en", 32'(rf_wr_en), 32'd0);
            check("post-reset resp_valid", 32'(resp_valid), 32'd0);
        end

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // r1 holds 0xFFFF; neither aborted command may change it.
        abort_case("abort_add_in_rd", 3'd3, 3'd1, 3'd3, 3'd4, 16'h0000, 1);
        abort_case("abort_ldi_in_wr", 3'd1, 3'd1, 3'd0, 3'd0, 16'h0BAD, 1);
        run_vec(100, v(2, 2, 1, 0, 16'h0000, 1, 3, 4, 2, 16'hFFFF, 0, 16'h0000, 16'hFFFF,
                       0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
